// File: rtl/sync_mutex_merge_n.sv
// N-channel synchronous mutual-exclusion merge: latches one-shot requests, grants one
// channel at a time and sequences the driveNext -> fire -> free handshake for it.

module sync_mutex_merge_n_pend (
    input  logic clk,
    input  logic rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_pend
);
    logic pend_q, pend_d;

    // A request arriving on the clearing edge survives the clear.
    always_comb pend_d = (pend_q & ~i_clr) | i_set;

    always_ff @(posedge clk) begin
        if (!rst) pend_q <= 1'b0;
        else      pend_q <= pend_d;
    end

    assign o_pend = pend_q;
endmodule

module sync_mutex_merge_n #(
    parameter int NUM_CH     = 2,
    parameter int FIRE_DELAY = 2,
    parameter int RR_MODE    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_drive,
    input  logic              i_freeNext,
    output logic              o_driveNext,
    output logic              o_fire,
    output logic [NUM_CH-1:0] o_data,
    output logic [NUM_CH-1:0] o_free,
    output logic              o_busy
);
    localparam int PW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

    generate
        if (NUM_CH < 2 || NUM_CH > 32) begin : g_bad_num_ch
            $error("sync_mutex_merge_n: NUM_CH must be in 2..32");
        end
        if (FIRE_DELAY < 1 || FIRE_DELAY > 15) begin : g_bad_fire_delay
            $error("sync_mutex_merge_n: FIRE_DELAY must be in 1..15");
        end
        if (RR_MODE != 0 && RR_MODE != 1) begin : g_bad_rr_mode
            $error("sync_mutex_merge_n: RR_MODE must be 0 or 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_GRANT     = 2'd1,
        S_WAIT_FREE = 2'd2,
        S_RELEASE   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic [NUM_CH-1:0] free_q, free_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              dn_q, dn_d;
    logic              fire_q, fire_d;
    logic              busy_q, busy_d;

    logic [NUM_CH-1:0] pend, clr, cand, win_oh;
    logic [PW-1:0]     win_idx, ptr_nxt;
    logic [PW:0]       start, idx;
    logic              win_found;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            sync_mutex_merge_n_pend u_pend (
                .clk   (clk),
                .rst   (rst),
                .i_set (i_drive[g]),
                .i_clr (clr[g]),
                .o_pend(pend[g])
            );
        end
    endgenerate

    // Rotating first-one search from the pointer; fixed priority starts at 0.
    always_comb begin
        cand      = pend | i_drive;
        start     = (RR_MODE != 0) ? {1'b0, ptr_q} : '0;
        idx       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = start + (PW+1)'(off);
            if (idx >= (PW+1)'(NUM_CH)) idx = idx - (PW+1)'(NUM_CH);
            if (!win_found && cand[idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[PW-1:0];
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
        ptr_nxt = (win_idx == PW'(NUM_CH-1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            free_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dn_q    <= 1'b0;
            fire_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            free_q  <= free_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dn_q    <= dn_d;
            fire_q  <= fire_d;
            busy_q  <= busy_d;
        end
    end

    // RELEASE arbitrates like IDLE so a waiting request is granted right after o_free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RELEASE: state_d = win_found ? S_GRANT : S_IDLE;
            S_GRANT:           if (cnt_q == 4'd1) state_d = S_WAIT_FREE;
            S_WAIT_FREE:       if (i_freeNext) state_d = S_RELEASE;
            default:           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dn_d   = 1'b0;
        fire_d = 1'b0;
        free_d = '0;
        clr    = '0;
        data_d = data_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        case (state_q)
            S_IDLE, S_RELEASE: begin
                if (win_found) begin
                    dn_d   = 1'b1;
                    data_d = win_oh;
                    busy_d = 1'b1;
                    cnt_d  = 4'(FIRE_DELAY);
                    if (RR_MODE != 0) ptr_d = ptr_nxt;
                end else begin
                    data_d = '0;
                    busy_d = 1'b0;
                end
            end
            S_GRANT: begin
                cnt_d  = cnt_q - 4'd1;
                fire_d = (cnt_q == 4'd1);
            end
            S_WAIT_FREE: begin
                if (i_freeNext) begin
                    free_d = data_q;
                    clr    = data_q;
                end
            end
            default: ;
        endcase
    end

    assign o_driveNext = dn_q;
    assign o_fire      = fire_q;
    assign o_data      = data_q;
    assign o_free      = free_q;
    assign o_busy      = busy_q;

    a_data_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(o_data));
    a_free_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(o_free));
    a_dn_fire_excl: assert property (@(posedge clk) disable iff (!rst) !(o_driveNext && o_fire));
endmodule

// File: tb/tb_sync_mutex_merge_n.sv
// Directed bench for sync_mutex_merge_n: 2-ch, 4-ch round-robin, 4-ch fixed priority
// and 32-ch instances share one clock and reset.

module tb_sync_mutex_merge_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    logic [1:0]  a_drv, a_data, a_free;
    logic        a_fnx, a_dn, a_fire, a_busy;
    logic [3:0]  q_drv [2];
    logic [3:0]  q_data[2];
    logic [3:0]  q_free[2];
    logic        q_fnx [2];
    logic        q_dn  [2];
    logic        q_fire[2];
    logic        q_busy[2];
    logic [31:0] w_drv, w_data, w_free;
    logic        w_fnx, w_dn, w_fire, w_busy;

    sync_mutex_merge_n #(.NUM_CH(2), .FIRE_DELAY(2), .RR_MODE(1)) u_a (
        .clk(clk), .rst(rst), .i_drive(a_drv), .i_freeNext(a_fnx), .o_driveNext(a_dn),
        .o_fire(a_fire), .o_data(a_data), .o_free(a_free), .o_busy(a_busy));
    sync_mutex_merge_n #(.NUM_CH(4), .FIRE_DELAY(2), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .i_drive(q_drv[0]), .i_freeNext(q_fnx[0]), .o_driveNext(q_dn[0]),
        .o_fire(q_fire[0]), .o_data(q_data[0]), .o_free(q_free[0]), .o_busy(q_busy[0]));
    sync_mutex_merge_n #(.NUM_CH(4), .FIRE_DELAY(2), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .i_drive(q_drv[1]), .i_freeNext(q_fnx[1]), .o_driveNext(q_dn[1]),
        .o_fire(q_fire[1]), .o_data(q_data[1]), .o_free(q_free[1]), .o_busy(q_busy[1]));
    sync_mutex_merge_n #(.NUM_CH(32), .FIRE_DELAY(15), .RR_MODE(1)) u_w (
        .clk(clk), .rst(rst), .i_drive(w_drv), .i_freeNext(w_fnx), .o_driveNext(w_dn),
        .o_fire(w_fire), .o_data(w_data), .o_free(w_free), .o_busy(w_busy));

    // Continuous exclusivity check on the 2-channel instance.
    always @(negedge clk) begin
        if (rst) begin
            n_total++;
            if (!$onehot0(a_data) || !$onehot0(a_free) || (a_dn && a_fire))
                $display("FAIL excl: data=%b free=%b dn=%b fire=%b", a_data, a_free, a_dn, a_fire);
            else n_pass++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; a_drv = 2'b11; q_drv[0] = 4'hf; w_drv = '1;
        step(); step();
        n_total++; if ({a_dn, a_fire, a_busy, a_data, a_free} !== 7'b0)
            $display("FAIL reset_a: got %b want 0", {a_dn, a_fire, a_busy, a_data, a_free}); else n_pass++;
        n_total++; if ({q_busy[0], q_data[0], w_busy, w_data} !== 38'b0)
            $display("FAIL reset_qw: got %h want 0", {q_busy[0], q_data[0], w_busy, w_data}); else n_pass++;
        a_drv = '0; q_drv[0] = '0; w_drv = '0; rst = 1'b1;
        step(); step();
        n_total++; if ({a_busy, q_busy[0], w_busy} !== 3'b000)
            $display("FAIL reset_discard: busy got %b want 000", {a_busy, q_busy[0], w_busy}); else n_pass++;
    endtask

    task automatic test_basic();
        a_drv = 2'b01; step(); a_drv = 2'b00;
        n_total++; if ({a_dn, a_data, a_busy, a_fire} !== 5'b10110)
            $display("FAIL basic_grant: got %b want 10110", {a_dn, a_data, a_busy, a_fire}); else n_pass++;
        step();
        n_total++; if ({a_dn, a_fire} !== 2'b00)
            $display("FAIL basic_gap: got %b want 00", {a_dn, a_fire}); else n_pass++;
        step();
        n_total++; if (a_fire !== 1'b1)
            $display("FAIL basic_fire: got %b want 1", a_fire); else n_pass++;
        step(); step();
        n_total++; if ({a_fire, a_free, a_busy} !== 4'b0001)
            $display("FAIL basic_wait: got %b want 0001", {a_fire, a_free, a_busy}); else n_pass++;
        a_fnx = 1'b1; step(); a_fnx = 1'b0;
        n_total++; if ({a_free, a_data, a_busy} !== 5'b01011)
            $display("FAIL basic_free: got %b want 01011", {a_free, a_data, a_busy}); else n_pass++;
        step();
        n_total++; if ({a_free, a_data, a_busy, a_dn} !== 6'b0)
            $display("FAIL basic_idle: got %b want 000000", {a_free, a_data, a_busy, a_dn}); else n_pass++;
    endtask

    task automatic test_free_early();
        a_drv = 2'b10; step(); a_drv = 2'b00; a_fnx = 1'b1;
        n_total++; if ({a_dn, a_data} !== 3'b110)
            $display("FAIL early_grant: got %b want 110", {a_dn, a_data}); else n_pass++;
        step();
        n_total++; if (a_free !== 2'b00)
            $display("FAIL early_pre_fire: free got %b want 00", a_free); else n_pass++;
        step();
        n_total++; if ({a_fire, a_free} !== 3'b100)
            $display("FAIL early_fire: got %b want 100", {a_fire, a_free}); else n_pass++;
        step();
        n_total++; if ({a_fire, a_free} !== 3'b010)
            $display("FAIL early_free: got %b want 010", {a_fire, a_free}); else n_pass++;
        step(); a_fnx = 1'b0;
        n_total++; if ({a_free, a_busy, a_data} !== 5'b0)
            $display("FAIL early_done: got %b want 00000", {a_free, a_busy, a_data}); else n_pass++;
    endtask

    task automatic test_requeue();
        int dn_cnt;
        a_drv = 2'b01; step();
        n_total++; if ({a_dn, a_data} !== 3'b101)
            $display("FAIL requeue_grant: got %b want 101", {a_dn, a_data}); else n_pass++;
        step(); a_drv = 2'b00;
        step();
        n_total++; if (a_fire !== 1'b1)
            $display("FAIL requeue_fire: got %b want 1", a_fire); else n_pass++;
        a_drv = 2'b01; step();
        a_fnx = 1'b1; step(); a_fnx = 1'b0; a_drv = 2'b00;
        n_total++; if (a_free !== 2'b01)
            $display("FAIL requeue_free: got %b want 01", a_free); else n_pass++;
        step();
        n_total++; if ({a_dn, a_data, a_busy} !== 4'b1011)
            $display("FAIL requeue_regrant: got %b want 1011", {a_dn, a_data, a_busy}); else n_pass++;
        step(); step();
        a_fnx = 1'b1; step(); a_fnx = 1'b0;
        n_total++; if (a_free !== 2'b01)
            $display("FAIL requeue_free2: got %b want 01", a_free); else n_pass++;
        dn_cnt = 0;
        for (int i = 0; i < 6; i++) begin step(); if (a_dn) dn_cnt++; end
        n_total++; if (dn_cnt !== 0 || a_busy !== 1'b0)
            $display("FAIL requeue_extra: grants got %0d busy %b want 0 0", dn_cnt, a_busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int evt;
        a_drv = 2'b01; step(); a_drv = 2'b10; step(); a_drv = 2'b00; step();
        n_total++; if (a_fire !== 1'b1)
            $display("FAIL rstmid_fire: got %b want 1", a_fire); else n_pass++;
        step();
        rst = 1'b0; a_fnx = 1'b1; step();
        n_total++; if ({a_dn, a_fire, a_data, a_free, a_busy} !== 7'b0)
            $display("FAIL rstmid_outs: got %b want 0", {a_dn, a_fire, a_data, a_free, a_busy}); else n_pass++;
        rst = 1'b1; a_fnx = 1'b0;
        evt = 0;
        for (int i = 0; i < 8; i++) begin step(); if (a_dn || a_free != 2'b00) evt++; end
        n_total++; if (evt !== 0 || a_busy !== 1'b0)
            $display("FAIL rstmid_after: events got %0d busy %b want 0 0", evt, a_busy); else n_pass++;
    endtask

    task automatic grant4(input int s, input int ch, input string nm);
        int n;
        logic [3:0] exp;
        exp = 4'b0001 << ch;
        n = 0;
        while (q_dn[s] !== 1'b1 && n < 20) begin step(); n++; end
        n_total++; if (q_dn[s] !== 1'b1 || q_data[s] !== exp)
            $display("FAIL %s_grant: dn %b data %b want 1 %b", nm, q_dn[s], q_data[s], exp); else n_pass++;
    endtask

    task automatic finish4(input int s, input int ch, input string nm);
        int n;
        logic [3:0] exp;
        exp = 4'b0001 << ch;
        n = 0;
        while (q_fire[s] !== 1'b1 && n < 20) begin step(); n++; end
        q_fnx[s] = 1'b1; step(); q_fnx[s] = 1'b0;
        n_total++; if (q_free[s] !== exp)
            $display("FAIL %s_free: got %b want %b", nm, q_free[s], exp); else n_pass++;
    endtask

    task automatic test_rr();
        q_drv[0] = 4'hf; step(); q_drv[0] = 4'h0;
        for (int ch = 0; ch < 4; ch++) begin
            grant4(0, ch, "rr");
            finish4(0, ch, "rr");
        end
        step(); step();
        n_total++; if (q_busy[0] !== 1'b0)
            $display("FAIL rr_idle: busy got %b want 0", q_busy[0]); else n_pass++;
    endtask

    task automatic test_prio();
        for (int s = 0; s < 2; s++) begin
            q_drv[s] = 4'b0010; step();
            grant4(s, 1, "prio_first");
            q_drv[s] = 4'b1001; step(); q_drv[s] = 4'b0000;
            n_total++; if (q_data[s] !== 4'b0010)
                $display("FAIL prio_hold: data got %b want 0010", q_data[s]); else n_pass++;
            finish4(s, 1, "prio_first");
            grant4(s, (s == 0) ? 3 : 0, "prio_second");
            finish4(s, (s == 0) ? 3 : 0, "prio_second");
            grant4(s, (s == 0) ? 0 : 3, "prio_third");
            finish4(s, (s == 0) ? 0 : 3, "prio_third");
            step(); step();
        end
        q_drv[1] = 4'b0101; step();
        grant4(1, 0, "fp_held");
        step(); q_drv[1] = 4'b0000;
        finish4(1, 0, "fp_held");
        grant4(1, 2, "fp_held2");
        finish4(1, 2, "fp_held2");
        step(); step();
        n_total++; if (q_busy[1] !== 1'b0)
            $display("FAIL fp_idle: busy got %b want 0", q_busy[1]); else n_pass++;
    endtask

    task automatic serve32(input int ch);
        int n;
        logic [31:0] exp;
        exp = 32'd1 << ch;
        n = 0;
        while (w_dn !== 1'b1 && n < 40) begin step(); n++; end
        n_total++; if (w_dn !== 1'b1 || w_data !== exp)
            $display("FAIL wide_grant: dn %b data %h want 1 %h", w_dn, w_data, exp); else n_pass++;
        n = 0;
        while (w_fire !== 1'b1 && n < 40) begin step(); n++; end
        n_total++; if (n !== 15)
            $display("FAIL wide_fire_delay: got %0d want 15", n); else n_pass++;
        w_fnx = 1'b1; step(); w_fnx = 1'b0;
        n_total++; if (w_free !== exp)
            $display("FAIL wide_free: got %h want %h", w_free, exp); else n_pass++;
    endtask

    task automatic test_wide();
        w_drv = 32'h4000_0000; step(); w_drv = '0;
        serve32(30);
        w_drv = 32'h8000_0020; step(); w_drv = '0;
        serve32(31);
        w_drv = 32'h8000_0000; step(); w_drv = '0;
        serve32(5);
        serve32(31);
        step(); step();
        n_total++; if (w_busy !== 1'b0)
            $display("FAIL wide_idle: busy got %b want 0", w_busy); else n_pass++;
    endtask

    initial begin
        a_drv = '0; a_fnx = 1'b0; w_drv = '0; w_fnx = 1'b0;
        for (int s = 0; s < 2; s++) begin q_drv[s] = '0; q_fnx[s] = 1'b0; end
        test_reset();
        test_basic();
        test_free_early();
        test_requeue();
        test_rr();
        test_prio();
        test_wide();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
